// File: rtl/csa_accum_resolve.sv
// Carry-save dot-product accumulator: folds compressor (sum, carry) pairs into a
// redundant accumulator, then resolves it to binary with a chunked carry-propagate adder.
module csa_accum_resolve #(
  parameter int IN_W    = 22,
  parameter int ACC_W   = 32,
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_sum,
  input  logic [IN_W:0]      in_carry,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [CNT_W-1:0]   out_beats
);

  localparam int K     = ACC_W / CHUNK_W;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  // S_COMMIT loads the result register in one step, so out_data never shows a partial value
  typedef enum logic [1:0] {
    S_ACCUM,
    S_RESOLVE,
    S_COMMIT,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ACC_W-1:0]   r_acc_s;
  logic [ACC_W-1:0]   r_acc_c;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_cc;
  logic [ACC_W-1:0]   r_work;
  logic [ACC_W-1:0]   r_out_data;
  logic [CNT_W-1:0]   r_out_beats;

  logic               w_accept;
  logic               w_last_chunk;
  logic [ACC_W-1:0]   w_in_s;
  logic [ACC_W-1:0]   w_in_c;
  logic [ACC_W-1:0]   w_s1;
  logic [ACC_W-1:0]   w_c1;
  logic [ACC_W-1:0]   w_s2;
  logic [ACC_W-1:0]   w_c2;
  logic [CHUNK_W:0]   w_chunk_sum;

  assign w_in_s = ACC_W'(in_sum);
  assign w_in_c = ACC_W'(in_carry);

  // Two 3:2 layers; each carry vector shifts left and drops its MSB (modulo 2^ACC_W)
  assign w_s1 = r_acc_s ^ r_acc_c ^ w_in_s;
  assign w_c1 = ((r_acc_s & r_acc_c) | (r_acc_s & w_in_s) | (r_acc_c & w_in_s)) << 1;
  assign w_s2 = w_s1 ^ w_c1 ^ w_in_c;
  assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_in_c) | (w_c1 & w_in_c)) << 1;

  assign w_chunk_sum = {1'b0, r_acc_s[CHUNK_W-1:0]}
                     + {1'b0, r_acc_c[CHUNK_W-1:0]}
                     + {{CHUNK_W{1'b0}}, r_cc};

  assign w_accept     = in_valid & in_ready;
  assign w_last_chunk = (r_idx == IDX_W'(K - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_state_next = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (w_last_chunk) begin
          w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_state_next = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_ACCUM;
        end
      end
      default: begin
        w_state_next = S_ACCUM;
      end
    endcase
  end

  // Resolve shifts both accumulator halves right a chunk per cycle, filling r_work from the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_s     <= '0;
      r_acc_c     <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_cc        <= 1'b0;
      r_work      <= '0;
      r_out_data  <= '0;
      r_out_beats <= '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          r_idx <= '0;
          r_cc  <= 1'b0;
          if (w_accept) begin
            r_acc_s <= w_s2;
            r_acc_c <= w_c2;
            if (r_cnt != {CNT_W{1'b1}}) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_RESOLVE: begin
          r_work  <= {w_chunk_sum[CHUNK_W-1:0], r_work[ACC_W-1:CHUNK_W]};
          r_cc    <= w_chunk_sum[CHUNK_W];
          r_acc_s <= r_acc_s >> CHUNK_W;
          r_acc_c <= r_acc_c >> CHUNK_W;
          r_idx   <= r_idx + 1'b1;
        end
        S_COMMIT: begin
          r_out_data  <= r_work;
          r_out_beats <= r_cnt;
        end
        S_OUT: begin
          if (out_ready) begin
            r_acc_s <= '0;
            r_acc_c <= '0;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;

endmodule

// File: tb/tb_csa_accum_resolve.sv
// Bench for csa_accum_resolve: scoreboarded runs from a vector table, plus hand-written
// sequences for latency, backpressure, reset mid-resolve and 24-bit wrap.
module tb_csa_accum_resolve;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [21:0] inSum;
  logic [22:0] inCarry;
  logic        inLast;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [7:0]  outBeats;

  logic        w24InValid;
  logic        w24InReady;
  logic [21:0] w24InSum;
  logic [22:0] w24InCarry;
  logic        w24InLast;
  logic        w24OutValid;
  logic        w24OutReady;
  logic [23:0] w24OutData;
  logic [7:0]  w24OutBeats;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  beats;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    int          nBeats;
    logic [21:0] sum;
    logic [22:0] carry;
    int          gapMax;
    logic [31:0] expData;
    logic [7:0]  expBeats;
  } vec_t;

  csa_accum_resolve dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_sum    (inSum),
    .in_carry  (inCarry),
    .in_last   (inLast),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_beats (outBeats)
  );

  csa_accum_resolve #(.ACC_W(24)) dut24 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w24InValid),
    .in_ready  (w24InReady),
    .in_sum    (w24InSum),
    .in_carry  (w24InCarry),
    .in_last   (w24InLast),
    .out_valid (w24OutValid),
    .out_ready (w24OutReady),
    .out_data  (w24OutData),
    .out_beats (w24OutBeats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard pops one expected result per handshake seen on the output
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (sbq.size() == 0) begin
        checkOutput("scoreboard depth", 64'(sbq.size()), 64'd1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("out_data", 64'(outData), 64'(e.data));
        checkOutput("out_beats", 64'(outBeats), 64'(e.beats));
      end
    end
  end

  task automatic applyStimulus(input logic [21:0] s, input logic [22:0] c, input logic last);
    inValid = 1'b1;
    inSum   = s;
    inCarry = c;
    inLast  = last;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic waitOut(input int expLat);
    int lat;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (outValid) begin
        lat = i;
        break;
      end
      checkOutput("in_ready while busy", 64'(inReady), 64'd0);
    end
    checkOutput("latency", 64'(lat), 64'(expLat));
  endtask

  task automatic runBeats(input int n, input logic [21:0] s, input logic [22:0] c, input int gapMax);
    for (int i = 0; i < n; i++) begin
      applyStimulus(s, c, (i == n - 1));
      if (gapMax > 0 && i < n - 1) begin
        // A lone in_last without in_valid must not end the run
        inLast = 1'b1;
        repeat ($urandom_range(0, gapMax)) @(posedge clk);
        #1;
        inLast = 1'b0;
      end
    end
  endtask

  task automatic runAndCheck(input int n, input logic [21:0] s, input logic [22:0] c,
                             input int gapMax, input logic [31:0] expData, input logic [7:0] expBeats);
    sbq.push_back({expData, expBeats});
    runBeats(n, s, c, gapMax);
    waitOut(5);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[6];
    logic [31:0] heldData;
    logic [7:0]  heldBeats;
    int lat24;

    vecs[0] = '{3,   22'h0,      23'h1,      0, 32'd3,        8'd3};
    vecs[1] = '{2,   22'h3FFFFF, 23'h7FFFFF, 1, 32'h017FFFFC, 8'd2};
    vecs[2] = '{5,   22'd12345,  23'd678,    3, 32'd65115,    8'd5};
    vecs[3] = '{400, 22'h3FFFFF, 23'h7FFFFF, 0, 32'h2BFFFCE0, 8'd255};
    vecs[4] = '{255, 22'd1,      23'd0,      0, 32'd255,      8'd255};
    vecs[5] = '{256, 22'd1,      23'd0,      0, 32'd256,      8'd255};

    rst         = 1'b1;
    inValid     = 1'b0;
    inSum       = '0;
    inCarry     = '0;
    inLast      = 1'b0;
    outReady    = 1'b1;
    w24InValid  = 1'b0;
    w24InSum    = '0;
    w24InCarry  = '0;
    w24InLast   = 1'b0;
    w24OutReady = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset out_valid", 64'(outValid), 64'd0);
    checkOutput("reset out_data", 64'(outData), 64'd0);
    checkOutput("reset out_beats", 64'(outBeats), 64'd0);
    checkOutput("reset in_ready", 64'(inReady), 64'd1);
    @(posedge clk);
    #1;

    $display("[TB] single beat");
    runAndCheck(1, 22'h3FFFFF, 23'h000002, 0, 32'h00400001, 8'd1);

    $display("[TB] four beats with gap");
    sbq.push_back({32'd4096, 8'd4});
    applyStimulus(22'd1000, 23'd24, 1'b0);
    applyStimulus(22'd1000, 23'd24, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(22'd1000, 23'd24, 1'b0);
    applyStimulus(22'd1000, 23'd24, 1'b1);
    waitOut(5);
    @(posedge clk);
    #1;

    $display("[TB] vector table");
    for (int v = 0; v < 6; v++) begin
      runAndCheck(vecs[v].nBeats, vecs[v].sum, vecs[v].carry, vecs[v].gapMax,
                  vecs[v].expData, vecs[v].expBeats);
    end

    $display("[TB] backpressure");
    outReady = 1'b0;
    sbq.push_back({32'h123, 8'd1});
    applyStimulus(22'h123, 23'd0, 1'b1);
    waitOut(5);
    heldData  = 32'h123;
    heldBeats = 8'd1;
    inValid = 1'b1;
    inSum   = 22'd7;
    inCarry = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("held out_valid", 64'(outValid), 64'd1);
      checkOutput("held out_data", 64'(outData), 64'(heldData));
      checkOutput("held out_beats", 64'(outBeats), 64'(heldBeats));
      checkOutput("held in_ready", 64'(inReady), 64'd0);
    end
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("released out_valid", 64'(outValid), 64'd0);
    checkOutput("released in_ready", 64'(inReady), 64'd1);
    @(posedge clk);
    #1;
    runAndCheck(1, 22'd7, 23'd0, 0, 32'd7, 8'd1);

    $display("[TB] reset mid-resolve");
    applyStimulus(22'd200, 23'd0, 1'b0);
    applyStimulus(22'd300, 23'd0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid-reset out_valid", 64'(outValid), 64'd0);
    checkOutput("mid-reset out_data", 64'(outData), 64'd0);
    checkOutput("mid-reset out_beats", 64'(outBeats), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset in_ready", 64'(inReady), 64'd1);
    @(posedge clk);
    #1;
    runAndCheck(1, 22'd5, 23'd0, 0, 32'd5, 8'd1);

    $display("[TB] 24-bit wrap");
    w24InSum   = 22'h3FFFFF;
    w24InCarry = 23'h400000;
    w24InValid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    w24InLast = 1'b1;
    @(posedge clk);
    #1;
    w24InValid = 1'b0;
    w24InLast  = 1'b0;
    lat24 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (w24OutValid) begin
        lat24 = i;
        break;
      end
    end
    checkOutput("wrap latency", 64'(lat24), 64'd4);
    checkOutput("wrap out_data", 64'(w24OutData), 64'h7FFFFD);
    checkOutput("wrap out_beats", 64'(w24OutBeats), 64'd3);
    @(posedge clk);
    #1;

    checkOutput("scoreboard drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
